// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble), one bit per clock.
// IDLE: accept operand | SHIFT: shift right and correct digits | DONE: hold result until taken
module bcd_to_bin_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [4*DIGITS-1:0]   i_in_bcd,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [BIN_W-1:0]      o_out_bin,
  output logic                  o_out_err,
  output logic                  o_busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  logic [BCD_W-1:0]   r_bcd;
  logic [BIN_W-1:0]   r_bin;
  logic [CNT_W-1:0]   r_count;
  logic [BIN_W-1:0]   r_out_bin;
  logic               r_out_err;
  logic               r_out_valid;
  logic               r_in_ready;
  logic               r_busy;

  logic [BCD_W+BIN_W-1:0] w_shift;
  logic [BCD_W-1:0]       w_bcd_adj;
  logic [BIN_W-1:0]       w_bin_next;
  logic                   w_bad_digit;

  // Digits that land at 8 or more after the halving step held a carried-in 10, so take 3 back off.
  always_comb begin
    w_shift    = {r_bcd, r_bin} >> 1;
    w_bin_next = w_shift[BIN_W-1:0];
    w_bcd_adj  = w_shift[BCD_W+BIN_W-1 -: BCD_W];
    for (int d = 0; d < DIGITS; d++) begin
      if (w_bcd_adj[4*d +: 4] >= 4'd8) begin
        w_bcd_adj[4*d +: 4] = w_bcd_adj[4*d +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    w_bad_digit = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (i_in_bcd[4*d +: 4] > 4'd9) begin
        w_bad_digit = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_bcd       <= '0;
      r_bin       <= '0;
      r_count     <= '0;
      r_out_bin   <= '0;
      r_out_err   <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (w_bad_digit) begin
              r_out_bin   <= '0;
              r_out_err   <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_bcd     <= i_in_bcd;
              r_bin     <= '0;
              r_count   <= '0;
              r_out_err <= 1'b0;
              r_state   <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_bcd   <= w_bcd_adj;
          r_bin   <= w_bin_next;
          r_count <= r_count + 1'b1;
          if (r_count == LAST) begin
            r_out_bin   <= w_bin_next;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_bin   = r_out_bin;
  assign o_out_err   = r_out_err;
  assign o_busy      = r_busy;

endmodule
